rect_draw_arbiter: RTL

Shares the single pixel-write port of `vga_adapter` among several drawing requesters: snake-segment draw, tail erase, apple draw, and later score/text. Each requester submits a filled rectangle (origin, size, colour). The block grants requesters round-robin, scans the granted rectangle one pixel per clock, and drives `plot`, x, y and colour to the adapter. It replaces the per-object counter pairs and hand-sequenced draw states in the top-level game FSM.

---
 rtl/draw_pkg.sv | 28 ++
 rtl/rect_draw_arbiter_if.sv | 36 +++
 rtl/rr_arbiter.sv | 32 +++
 rtl/rect_draw_arbiter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// Shared types and constants for the rectangle draw path.
package draw_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StDraw = 2'd1,
        StDone = 2'd2
    } draw_state_e;

    localparam int unsigned XSCREEN_DEF = 160;
    localparam int unsigned YSCREEN_DEF = 120;
    localparam int unsigned XW_DEF      = 8;
    localparam int unsigned YW_DEF      = 7;
    localparam int unsigned CW_DEF      = 3;

    // 3-bit colours as {r, g, b}
    localparam logic [CW_DEF-1:0] BLACK = 3'b000;
    localparam logic [CW_DEF-1:0] RED   = 3'b100;
    localparam logic [CW_DEF-1:0] GREEN = 3'b010;

    // (a + b) mod n, valid for a, b < n
    function automatic int unsigned wrap_add(int unsigned a, int unsigned b, int unsigned n);
        int unsigned s;
        s = a + b;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/rect_draw_arbiter_if.sv
// Requester-side and pixel-side signals of the rectangle draw arbiter.
interface rect_draw_arbiter_if #(
    parameter int unsigned N_REQ = 3,
    parameter int unsigned XW    = 8,
    parameter int unsigned YW    = 7,
    parameter int unsigned DW    = 4,
    parameter int unsigned CW    = 3
) ();

    logic [N_REQ-1:0]    req;
    logic [N_REQ*XW-1:0] rect_x;
    logic [N_REQ*YW-1:0] rect_y;
    logic [N_REQ*DW-1:0] rect_w;
    logic [N_REQ*DW-1:0] rect_h;
    logic [N_REQ*CW-1:0] rect_colour;
    logic [N_REQ-1:0]    grant;
    logic [N_REQ-1:0]    done;
    logic                busy;
    logic                plot;
    logic [XW-1:0]       vga_x;
    logic [YW-1:0]       vga_y;
    logic [CW-1:0]       vga_colour;

    // Drawing requesters plus the pixel consumer.
    modport master (
        output req, rect_x, rect_y, rect_w, rect_h, rect_colour,
        input  grant, done, busy, plot, vga_x, vga_y, vga_colour
    );

    // The arbiter itself.
    modport slave (
        input  req, rect_x, rect_y, rect_w, rect_h, rect_colour,
        output grant, done, busy, plot, vga_x, vga_y, vga_colour
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter; the search starts at ptr, which the parent owns.
module rr_arbiter
    import draw_pkg::*;
#(
    parameter  int unsigned N  = 3,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          valid
);

    // First requester at or after ptr, wrapping, wins.
    always_comb begin
        int unsigned k;
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        k     = 0;
        for (int unsigned i = 0; i < N; i++) begin
            k = wrap_add(32'(ptr), i, N);
            if (!valid && req[k[IW-1:0]]) begin
                valid            = 1'b1;
                idx              = k[IW-1:0];
                gnt[k[IW-1:0]]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rect_draw_arbiter.sv
// Shares the vga_adapter pixel port among rectangle requesters: round-robin grant,
// then a one-pixel-per-clock raster scan of the granted filled rectangle.
module rect_draw_arbiter
    import draw_pkg::*;
#(
    parameter int unsigned N_REQ   = 3,
    parameter int unsigned XW      = XW_DEF,
    parameter int unsigned YW      = YW_DEF,
    parameter int unsigned DW      = 4,
    parameter int unsigned CW      = CW_DEF,
    parameter int unsigned XSCREEN = XSCREEN_DEF,
    parameter int unsigned YSCREEN = YSCREEN_DEF
) (
    input logic          Clock,
    input logic          Resetn,
    rect_draw_arbiter_if.slave bus
);

    localparam int unsigned IW = $clog2(N_REQ);
    localparam logic [XW:0] XLIM = (XW+1)'(XSCREEN);
    localparam logic [YW:0] YLIM = (YW+1)'(YSCREEN);

    draw_state_e       state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     gidx_q, gidx_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [XW-1:0]     x0_q, x0_d;
    logic [YW-1:0]     y0_q, y0_d;
    logic [DW-1:0]     w_q, w_d;
    logic [DW-1:0]     h_q, h_d;
    logic [CW-1:0]     col_q, col_d;
    logic [DW-1:0]     xc_q, xc_d;
    logic [DW-1:0]     yc_q, yc_d;

    logic [N_REQ-1:0]  arb_gnt;
    logic [IW-1:0]     arb_idx;
    logic              arb_valid;

    logic [XW-1:0]     req_x;
    logic [YW-1:0]     req_y;
    logic [DW-1:0]     req_w;
    logic [DW-1:0]     req_h;
    logic [CW-1:0]     req_col;

    logic              in_draw;
    logic [XW:0]       sum_x;
    logic [YW:0]       sum_y;

    rr_arbiter #(
        .N (N_REQ)
    ) u_rr (
        .req   (bus.req),
        .ptr   (ptr_q),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    // Unpack the winning requester's rectangle fields.
    always_comb begin
        req_x   = '0;
        req_y   = '0;
        req_w   = '0;
        req_h   = '0;
        req_col = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (arb_idx == IW'(i)) begin
                req_x   = bus.rect_x[i*XW +: XW];
                req_y   = bus.rect_y[i*YW +: YW];
                req_w   = bus.rect_w[i*DW +: DW];
                req_h   = bus.rect_h[i*DW +: DW];
                req_col = bus.rect_colour[i*CW +: CW];
            end
        end
    end

    // Next-state: arbitration in IDLE, raster stepping in DRAW, release in DONE.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        grant_d = grant_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        w_d     = w_q;
        h_d     = h_q;
        col_d   = col_q;
        xc_d    = xc_q;
        yc_d    = yc_q;
        unique case (state_q)
            StIdle: begin
                if (arb_valid) begin
                    gidx_d  = arb_idx;
                    grant_d = arb_gnt;
                    x0_d    = req_x;
                    y0_d    = req_y;
                    w_d     = req_w;
                    h_d     = req_h;
                    col_d   = req_col;
                    xc_d    = '0;
                    yc_d    = '0;
                    // Empty rectangles still produce a done pulse, just no pixels.
                    state_d = (req_w == '0 || req_h == '0) ? StDone : StDraw;
                end
            end
            StDraw: begin
                if (xc_q == w_q - DW'(1)) begin
                    xc_d = '0;
                    yc_d = yc_q + DW'(1);
                    if (yc_q == h_q - DW'(1)) begin
                        state_d = StDone;
                    end
                end else begin
                    xc_d = xc_q + DW'(1);
                end
            end
            StDone: begin
                grant_d = '0;
                ptr_d   = IW'(wrap_add(32'(gidx_q), 1, N_REQ));
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            gidx_q  <= '0;
            grant_q <= '0;
            x0_q    <= '0;
            y0_q    <= '0;
            w_q     <= '0;
            h_q     <= '0;
            col_q   <= '0;
            xc_q    <= '0;
            yc_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            grant_q <= grant_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            w_q     <= w_d;
            h_q     <= h_d;
            col_q   <= col_d;
            xc_q    <= xc_d;
            yc_q    <= yc_d;
        end
    end

    // Outputs decode from registers only; wide sums catch off-screen pixels.
    always_comb begin
        in_draw        = (state_q == StDraw);
        sum_x          = {1'b0, x0_q} + {{(XW+1-DW){1'b0}}, xc_q};
        sum_y          = {1'b0, y0_q} + {{(YW+1-DW){1'b0}}, yc_q};
        bus.busy       = (state_q != StIdle);
        bus.grant      = grant_q;
        bus.done       = (state_q == StDone) ? grant_q : '0;
        bus.plot       = in_draw && (sum_x < XLIM) && (sum_y < YLIM);
        bus.vga_x      = in_draw ? sum_x[XW-1:0] : '0;
        bus.vga_y      = in_draw ? sum_y[YW-1:0] : '0;
        bus.vga_colour = in_draw ? col_q : '0;
    end

endmodule
